// File: rtl/instr_fetch.sv
// Instruction fetch: credit-limited request stream to instruction memory, in-order response
// buffering toward decode, and redirect handling that discards stale in-flight responses.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_instr,
  output logic [6:0]  dec_opcode,
  output logic [2:0]  dec_func3,
  output logic [6:0]  dec_func7
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;
  typedef logic [CntW:0]   used_t;

  localparam ptr_t  LastPtr = ptr_t'(DEPTH - 1);
  localparam used_t Credits = used_t'(DEPTH);
  localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == LastPtr) ? '0 : p + ptr_t'(1);
  endfunction

  logic [31:0] fetch_pc_q, fetch_pc_d;
  cnt_t        outstanding_q, outstanding_d;
  cnt_t        drop_q, drop_d;
  cnt_t        count_q, count_d;
  ptr_t        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  ptr_t        pcq_rd_q, pcq_rd_d, pcq_wr_q, pcq_wr_d;
  logic [31:0] buf_pc_q    [DEPTH];
  logic [31:0] buf_instr_q [DEPTH];
  logic [31:0] pcq_q       [DEPTH];

  logic  req_xfer, rsp_keep, push, pop;
  used_t credits_used;
  logic  unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Credits cover both in-flight requests and buffered entries, so every response has a slot.
  assign credits_used   = {1'b0, outstanding_q} + {1'b0, count_q};
  assign imem_req_valid = rst_n && !redirect_valid && (credits_used < Credits);
  assign imem_req_addr  = fetch_pc_q;
  assign req_xfer       = imem_req_valid && imem_req_ready;

  assign dec_valid  = (count_q != '0);
  assign dec_pc     = buf_pc_q[rd_ptr_q];
  assign dec_instr  = buf_instr_q[rd_ptr_q];
  assign dec_opcode = dec_instr[6:0];
  assign dec_func3  = dec_instr[14:12];
  assign dec_func7  = dec_instr[31:25];

  assign rsp_keep = imem_rsp_valid && (drop_q == '0);
  assign push     = rsp_keep && !redirect_valid;
  assign pop      = dec_valid && dec_ready && !redirect_valid;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + cnt_t'(req_xfer) - cnt_t'(imem_rsp_valid);
    drop_d        = drop_q;
    count_d       = count_q + cnt_t'(push) - cnt_t'(pop);
    rd_ptr_d      = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d      = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    pcq_wr_d      = req_xfer ? ptr_inc(pcq_wr_q) : pcq_wr_q;
    pcq_rd_d      = imem_rsp_valid ? ptr_inc(pcq_rd_q) : pcq_rd_q;

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      // Everything still in flight after this edge belongs to the abandoned path.
      drop_d     = outstanding_d;
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
      wr_ptr_d   = wr_ptr_q;
    end else begin
      if (req_xfer) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (imem_rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= ResetPcAligned;
      outstanding_q <= '0;
      drop_q        <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      pcq_rd_q      <= '0;
      pcq_wr_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_pc_q[i]    <= '0;
        buf_instr_q[i] <= '0;
        pcq_q[i]       <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      pcq_rd_q      <= pcq_rd_d;
      pcq_wr_q      <= pcq_wr_d;
      if (req_xfer) begin
        pcq_q[pcq_wr_q] <= fetch_pc_q;
      end
      if (push) begin
        buf_pc_q[wr_ptr_q]    <= pcq_q[pcq_rd_q];
        buf_instr_q[wr_ptr_q] <= imem_rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: cycle-table for the flow-control run, hand sequences for
// redirect, flush, address wrap and mid-stream reset.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_pc, dec_instr;
  logic [6:0]  dec_opcode, dec_func7;
  logic [2:0]  dec_func3;

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .dec_pc        (dec_pc),
    .dec_instr     (dec_instr),
    .dec_opcode    (dec_opcode),
    .dec_func3     (dec_func3),
    .dec_func7     (dec_func7)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    bit          dec_rdy;
    bit          exp_rv;
    logic [31:0] exp_ra;
    bit          exp_dv;
    logic [31:0] exp_dpc;
  } vec_t;

  mreq_t mq[$];
  vec_t  tbl[16];
  int    cyc, mem_lat, n_checks, n_fail;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0020_81B3 + (a << 5);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at the negedge after checks: records a handshake, advances, drives any response.
  task automatic tick();
    mreq_t r;
    if (imem_req_valid && imem_req_ready) begin
      r.addr = imem_req_addr;
      r.due  = cyc + mem_lat;
      if (mq.size() > 0 && r.due <= mq[$].due) r.due = mq[$].due + 1;
      mq.push_back(r);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    dec_ready      = 1'b0;
    mq.delete();
    @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_dec_valid", 32'(dec_valid), 32'h0);
    chk("rst_dec_pc", dec_pc, 32'h0);
    chk("rst_dec_instr", dec_instr, 32'h0);
    chk("rst_dec_fields", {15'h0, dec_opcode, dec_func3, dec_func7}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  // Bounded wait for the next presented instruction; leaves the caller at the sampling point.
  task automatic wait_dec(input string name, input logic [31:0] exp_pc);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (dec_valid) begin
        chk({name, "_pc"}, dec_pc, exp_pc);
        chk({name, "_instr"}, dec_instr, mem_word(exp_pc));
        return;
      end
      tick();
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s: dec_valid never rose, expected pc %h", name, exp_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    mem_lat  = 1;

    // dec_ready low for 10 cycles, then released; memory always ready, 1-cycle latency.
    tbl[0]  = '{0, 1, 32'h0,  0, 32'h0};
    tbl[1]  = '{0, 1, 32'h4,  0, 32'h0};
    for (int i = 2; i < 10; i++) tbl[i] = '{0, 0, 32'h0, 1, 32'h0};
    tbl[10] = '{1, 0, 32'h0,  1, 32'h0};
    tbl[11] = '{1, 1, 32'h8,  1, 32'h4};
    tbl[12] = '{1, 1, 32'hC,  0, 32'h0};
    tbl[13] = '{1, 0, 32'h0,  1, 32'h8};
    tbl[14] = '{1, 1, 32'h10, 1, 32'hC};
    tbl[15] = '{1, 1, 32'h14, 0, 32'h0};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      dec_ready = tbl[i].dec_rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].exp_rv));
      if (tbl[i].exp_rv) chk($sformatf("tbl%0d_req_addr", i), imem_req_addr, tbl[i].exp_ra);
      chk($sformatf("tbl%0d_dec_valid", i), 32'(dec_valid), 32'(tbl[i].exp_dv));
      if (tbl[i].exp_dv) begin
        w = mem_word(tbl[i].exp_dpc);
        chk($sformatf("tbl%0d_dec_pc", i), dec_pc, tbl[i].exp_dpc);
        chk($sformatf("tbl%0d_dec_instr", i), dec_instr, w);
        chk($sformatf("tbl%0d_fields", i), {15'h0, dec_opcode, dec_func3, dec_func7},
            {15'h0, w[6:0], w[14:12], w[31:25]});
      end
      if (i == 2) begin
        chk("first_opcode", 32'(dec_opcode), 32'h33);
        chk("first_func3", 32'(dec_func3), 32'h0);
        chk("first_func7", 32'(dec_func7), 32'h0);
      end
      tick();
    end

    // Redirect with two requests outstanding: both stale responses must be dropped.
    mem_lat = 3;
    do_reset();
    dec_ready = 1'b1;
    @(negedge clk); chk("redir_c0_addr", imem_req_addr, 32'h0); tick();
    @(negedge clk); chk("redir_c1_addr", imem_req_addr, 32'h4); tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    @(negedge clk); chk("redir_c2_req_valid", 32'(imem_req_valid), 32'h0); tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_c3_dec_valid", 32'(dec_valid), 32'h0);
    chk("redir_c3_req_valid", 32'(imem_req_valid), 32'h0);
    tick();
    @(negedge clk);
    chk("redir_c4_req_valid", 32'(imem_req_valid), 32'h1);
    chk("redir_c4_addr", imem_req_addr, 32'h100);
    tick();
    wait_dec("redir_first", 32'h100);
    tick();
    wait_dec("redir_second", 32'h104);
    tick();

    // Redirect coinciding with a decode pop and a response push.
    mem_lat = 1;
    do_reset();
    dec_ready = 1'b1;
    @(negedge clk); tick();
    @(negedge clk); tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    @(negedge clk);
    chk("flush_c2_dec_valid", 32'(dec_valid), 32'h1);
    chk("flush_c2_rsp_valid", 32'(imem_rsp_valid), 32'h1);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("flush_c3_dec_valid", 32'(dec_valid), 32'h0);
    chk("flush_c3_addr", imem_req_addr, 32'h200);
    tick();
    wait_dec("flush_first", 32'h200);
    tick();

    // Fetch address wraps from the top of the address space to zero.
    do_reset();
    dec_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    @(negedge clk); chk("wrap_c0_req_valid", 32'(imem_req_valid), 32'h0); tick();
    redirect_valid = 1'b0;
    @(negedge clk); chk("wrap_c1_addr", imem_req_addr, 32'hFFFF_FFFC); tick();
    @(negedge clk);
    chk("wrap_c2_req_valid", 32'(imem_req_valid), 32'h1);
    chk("wrap_c2_addr", imem_req_addr, 32'h0);
    tick();
    wait_dec("wrap_first", 32'hFFFF_FFFC);
    tick();
    wait_dec("wrap_second", 32'h0);
    tick();

    // Mid-stream reset with two requests in flight.
    mem_lat = 2;
    do_reset();
    @(negedge clk); tick();
    @(negedge clk); tick();
    @(negedge clk);
    chk("mrst_pre_rsp_valid", 32'(imem_rsp_valid), 32'h1);
    rst_n = 1'b0;
    mq.delete();
    imem_rsp_valid = 1'b0;
    #1;
    chk("mrst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("mrst_dec_valid", 32'(dec_valid), 32'h0);
    chk("mrst_dec_pc", dec_pc, 32'h0);
    chk("mrst_dec_instr", dec_instr, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n          = 1'b1;
    cyc            = 0;
    imem_req_ready = 1'b0;
    @(negedge clk);
    chk("mrst_r0_req_valid", 32'(imem_req_valid), 32'h1);
    chk("mrst_r0_addr", imem_req_addr, 32'h0);
    tick();
    @(negedge clk);
    chk("mrst_r1_hold_valid", 32'(imem_req_valid), 32'h1);
    chk("mrst_r1_hold_addr", imem_req_addr, 32'h0);
    chk("mrst_r1_dec_valid", 32'(dec_valid), 32'h0);
    tick();
    imem_req_ready = 1'b1;
    dec_ready      = 1'b1;
    @(negedge clk);
    chk("mrst_r2_addr", imem_req_addr, 32'h0);
    tick();
    wait_dec("mrst_first", 32'h0);
    tick();
    wait_dec("mrst_second", 32'h4);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
